// File: rtl/key_event_encoder.sv
// key_event_encoder
//   Scans a bank of debounced key lines one key per cycle, compares each line
//   with the last level it reported, and queues a press/release event into a
//   first-word fall-through FIFO whenever the two differ.
//
// Ports
//   clk_i          single clock, rising edge
//   rst_i          asynchronous active-high reset
//   keys_i         [KEYS]  debounced key levels, 0 = pressed
//   scan_en_i      1 = scan pointer advances and compares
//   event_o        [8]     FIFO head: {press, 1'b0, key[5:0]}
//   event_valid_o  head valid (FIFO not empty)
//   event_ready_i  consumer accepts head when valid
//   fifo_count_o   occupied FIFO entries
//   retry_o        sticky: a change was seen while the FIFO was full
//   retry_clr_i    synchronous clear for retry_o (a same-cycle set wins)
module key_event_encoder #(
  parameter int KEYS       = 61,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [KEYS-1:0]               keys_i,
  input  logic                          scan_en_i,
  output logic [7:0]                    event_o,
  output logic                          event_valid_o,
  input  logic                          event_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          retry_o,
  input  logic                          retry_clr_i
);

  localparam int PW = (KEYS > 1) ? $clog2(KEYS) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic       press;
    logic       rsvd;
    logic [5:0] key;
  } key_event_t;

  logic [KEYS-1:0]  snap;
  logic [PW-1:0]    ptr;
  key_event_t       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             retry;

  logic             cur_lvl;
  logic             mismatch;
  logic             full;
  logic             push;
  logic             pop;
  key_event_t       new_ev;

  assign cur_lvl  = keys_i[ptr];
  assign mismatch = scan_en_i && (cur_lvl != snap[ptr]);
  // Full comes from the registered count, so a pop in the same cycle never
  // opens room for a push.
  assign full     = (count == CW'(FIFO_DEPTH));
  assign push     = mismatch && !full;
  assign pop      = event_valid_o && event_ready_i;

  always_comb begin
    new_ev       = '0;
    new_ev.press = ~cur_lvl;
    new_ev.key   = 6'(ptr);
  end

  // Scan pointer and snapshot. The snapshot only follows the key when the
  // event is actually queued; a dropped change stays visible for the next sweep.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr  <= '0;
      snap <= '1;
    end else if (scan_en_i) begin
      if (ptr == PW'(KEYS - 1)) ptr <= '0;
      else                      ptr <= ptr + 1'b1;
      if (push) snap[ptr] <= cur_lvl;
    end
  end

  // FIFO storage needs no reset: the output is gated by valid.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= new_ev;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                 retry <= 1'b0;
    else if (mismatch && full) retry <= 1'b1;
    else if (retry_clr_i)      retry <= 1'b0;
  end

  assign event_valid_o = (count != '0);
  assign event_o       = event_valid_o ? mem[rd_ptr] : 8'h00;
  assign fifo_count_o  = count;
  assign retry_o       = retry;

endmodule

// File: doc/key_event_encoder.md
KEY_EVENT_ENCODER -- requirements
Module: key_event_encoder

Interface
REQ-001 The block SHALL have parameter KEYS, default 61, meaning the number of debounced key lines; legal range 1..64.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, meaning the number of event FIFO entries; it SHALL be a power of two, 2..64.
REQ-003 The block SHALL have port clk_i, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit, reset, asynchronous and active-high.
REQ-005 The block SHALL have port keys_i, input, KEYS bits, debounced key levels, 0 = pressed, 1 = released.
REQ-006 The block SHALL have port scan_en_i, input, 1 bit; 1 = scanning enabled.
REQ-007 The block SHALL have port event_o, output, 8 bits, the FIFO head event: bit7 = 1 press / 0 release, bit6 = 0, bits5:0 = key index.
REQ-008 The block SHALL have port event_valid_o, output, 1 bit; 1 = event_o holds a valid event.
REQ-009 The block SHALL have port event_ready_i, input, 1 bit; the consumer accepts event_o when this and event_valid_o are both 1.
REQ-010 The block SHALL have port fifo_count_o, output, clog2(FIFO_DEPTH)+1 bits, the number of occupied FIFO entries.
REQ-011 The block SHALL have port retry_o, output, 1 bit, a sticky flag that is set when a detected change cannot be queued because the FIFO is full.
REQ-012 The block SHALL have port retry_clr_i, input, 1 bit, a synchronous clear for retry_o.

Function
REQ-013 The block SHALL hold a KEYS-bit snapshot register of last-reported key levels.
REQ-014 The block SHALL hold a scan pointer that steps 0,1,...,KEYS-1 and wraps to 0, one step per cycle while scan_en_i=1, and holds while scan_en_i=0.
REQ-015 Each cycle with scan_en_i=1, the block SHALL compare keys_i[ptr] with snapshot[ptr].
REQ-016 On mismatch with fifo_count_o < FIFO_DEPTH, the block SHALL push {~keys_i[ptr], 1'b0, ptr[5:0]} and update snapshot[ptr] to keys_i[ptr] in the same cycle.
REQ-017 On mismatch with fifo_count_o = FIFO_DEPTH, the block SHALL push nothing, leave snapshot[ptr] unchanged, and set retry_o; the change is re-detected on a later sweep.
REQ-018 A change that reverts before its key is re-scanned SHALL produce no event.
REQ-019 Full is evaluated from the count at the start of the cycle; a same-cycle pop SHALL NOT permit a push into a full FIFO.
REQ-020 The FIFO SHALL be first-word fall-through: event_valid_o = (fifo_count_o != 0), and event_o = head entry whenever event_valid_o=1.
REQ-021 A pop SHALL occur when event_valid_o=1 and event_ready_i=1.
REQ-022 On simultaneous push and pop, fifo_count_o SHALL be unchanged and ordering SHALL be preserved.
REQ-023 Push latency SHALL be 1 cycle: an event pushed at edge N, into an empty FIFO, SHALL drive event_valid_o=1 after edge N.
REQ-024 Worst-case latency from a stable change to its push SHALL be KEYS cycles, given a non-full FIFO and scan_en_i=1.
REQ-025 Events SHALL leave the FIFO in push order; the FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 event_o and event_valid_o SHALL NOT change while event_valid_o=1 and event_ready_i=0, except that event_valid_o stays 1.
REQ-027 If retry_clr_i and a new retry condition occur in the same cycle, the set SHALL win.

Reset
REQ-028 While rst_i=1, the snapshot SHALL be all ones (all released), ptr = 0, fifo_count_o = 0, event_valid_o = 0, event_o = 0, and retry_o = 0.
REQ-029 Reset asserted mid-operation SHALL discard all queued events immediately, without waiting for a clock edge.
REQ-030 After rst_i deasserts, keys already held pressed SHALL be reported as press events on the first sweep.

Verification
REQ-031 Basic press/release: reset, all keys released; then keys_i[5]=0 -> exactly one event 0x85; then keys_i[5]=1 -> exactly one event 0x05.
REQ-032 Ordering and high index: keys 60 and 2 pressed in the same cycle -> events 0x82 then 0xBC, in scan order from ptr.
REQ-033 Full FIFO: event_ready_i=0 with 10 keys pressed -> fifo_count_o = 8 and retry_o = 1; then event_ready_i=1 -> all 10 press events delivered with no duplicates.
REQ-034 Backpressure: with event_valid_o=1, event_ready_i held 0 for 5 cycles -> event_o stable; one-cycle ready pulse -> exactly one pop.
REQ-035 Reset mid-stream: rst_i=1 with 4 events queued -> event_valid_o = 0 with no clock edge; after release, keys still pressed are re-reported.
REQ-036 scan_en_i=0 while key 7 is pressed -> no event; set scan_en_i=1 -> 0x87 within 61 cycles.
